multiplicador_algoritmico: RTL and testbench

Sequential signed shift-add multiply-accumulate unit computing Prod = Coc·Den + Res at double width. It is the inverse companion of the algorithmic divider. It rebuilds the dividend from a quotient, divisor and remainder, either for self-checking division results or as a general multi-cycle multiplier. It uses the same Start/Done handshake as the divider, so both blocks can share one controller.

---
 rtl/multiplicador_algoritmico.sv | 66 ++++++
 tb/tb_multiplicador_algoritmico.sv | 125 ++++++++++++
 2 files changed

// File: rtl/multiplicador_algoritmico.sv
// multiplicador_algoritmico: sequential signed shift-add MAC, Prod = Coc*Den + Res at double width.
// Optional MULT_EARLY_EXIT_EN ends iteration as soon as the remaining multiplier bits are all zero.
module multiplicador_algoritmico #(
  parameter int tamanyo = 32
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   Start,
  input  logic [tamanyo-1:0]     Coc,
  input  logic [tamanyo-1:0]     Den,
  input  logic [tamanyo-1:0]     Res,
  output logic [2*tamanyo-1:0]   Prod,
  output logic                   Ovf,
  output logic                   Done
);
  localparam int W = tamanyo;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  state_t state, state_n;
  logic sa, sb, last;
  logic [CW-1:0] cnt;
  logic [W-1:0] mplier;
  logic [2*W-1:0] mcand, acc, addend, prod_n;
  logic [W:0] top;
`ifdef MULT_EARLY_EXIT_EN
  assign last = cnt == CW'(W-1) || mplier[W-1:1] == '0;
`else
  assign last = cnt == CW'(W-1);
`endif
  // magnitudes are multiplied unsigned, the sign is reapplied before adding Res
  assign prod_n = ((sa ^ sb) ? ~acc + 1'b1 : acc) + addend;
  assign top = prod_n[2*W-1:W-1];
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (Start ? ITER : IDLE) : state == ITER ? (last ? FIX : ITER) : IDLE;
  end
  always_ff @(posedge CLK or negedge RSTa)
    if (!RSTa) begin
      state <= IDLE;
      Prod <= '0;
      Ovf <= 1'b0;
      Done <= 1'b0;
    end else begin
      state <= state_n;
      Done <= state == FIX;
      if (state == FIX) begin
        Prod <= prod_n;
        Ovf <= !(top == '0 || top == '1);
      end
    end
  always_ff @(posedge CLK)
    if (state == IDLE && Start) begin
      sa <= Coc[W-1];
      sb <= Den[W-1];
      mcand <= {{W{1'b0}}, Coc[W-1] ? ~Coc + 1'b1 : Coc};
      mplier <= Den[W-1] ? ~Den + 1'b1 : Den;
      addend <= {{W{Res[W-1]}}, Res};
      acc <= '0;
      cnt <= '0;
    end else if (state == ITER) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_multiplicador_algoritmico.sv
// tb_multiplicador_algoritmico: directed checks of the signed MAC, reset abort and back-to-back Start.
module tb_multiplicador_algoritmico;
  localparam int W = 32;
  logic CLK = 1'b0, RSTa = 1'b0, Start = 1'b0;
  logic [W-1:0] Coc = '0, Den = '0, Res = '0;
  logic [2*W-1:0] Prod;
  logic Ovf, Done;
  int checks = 0, failures = 0;

  multiplicador_algoritmico #(.tamanyo(W)) dut (
    .CLK(CLK), .RSTa(RSTa), .Start(Start), .Coc(Coc), .Den(Den), .Res(Res),
    .Prod(Prod), .Ovf(Ovf), .Done(Done));

  always #5 CLK = ~CLK;

  function automatic int exp_lat(input logic [31:0] d);
`ifdef MULT_EARLY_EXIT_EN
    logic [31:0] m = d[31] ? -d : d;
    int n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n + 1;
`else
    return W + 1;
`endif
  endfunction

  task automatic run_op(input logic [31:0] c, d, r, output logic [63:0] p, output logic o, output int lat);
    Start = 1'b1; Coc = c; Den = d; Res = r;
    @(posedge CLK); #1;
    Start = 1'b0; Coc = $urandom; Den = $urandom; Res = $urandom;
    lat = 0;
    do begin @(posedge CLK); #1; lat++; end while (!Done && lat < 100);
    p = Prod; o = Ovf;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (Prod !== 64'd0) begin failures++; $display("FAIL reset_prod got=%h exp=0", Prod); end
    checks++; if (Ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", Ovf); end
    checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", Done); end
    RSTa = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_directed;
    logic [31:0] vc[10] = '{32'd7, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'h80000000,
                            32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0, 32'd5, 32'd3};
    logic [31:0] vd[10] = '{32'd3, 32'd3, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000,
                            32'd1, 32'd1, 32'd0, 32'd5, 32'h80000000};
    logic [31:0] vr[10] = '{32'd2, 32'hFFFFFFFE, 32'd2, 32'd0, 32'hFFFFFFFF,
                            32'd0, 32'd1, 32'hFFFFFFF7, 32'd0, 32'd0};
    logic [63:0] vp[10] = '{64'd23, 64'hFFFFFFFFFFFFFFE9, 64'hFFFFFFFFFFFFFFED, 64'h0000000080000000,
                            64'h3FFFFFFFFFFFFFFF, 64'h000000007FFFFFFF, 64'h0000000080000000,
                            64'hFFFFFFFFFFFFFFF7, 64'd25, 64'hFFFFFFFE80000000};
    logic       vo[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [63:0] p;
    logic o;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(vc[i], vd[i], vr[i], p, o, lat);
      checks++; if (lat !== exp_lat(vd[i])) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, exp_lat(vd[i])); end
      checks++; if (p !== vp[i]) begin failures++; $display("FAIL dir%0d_prod got=%h exp=%h", i, p, vp[i]); end
      checks++; if (o !== vo[i]) begin failures++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, o, vo[i]); end
    end
  endtask

  task automatic test_abort;
    logic [63:0] p;
    logic o;
    int lat, pulses = 0;
    Start = 1'b1; Coc = 32'd100; Den = 32'd100; Res = 32'd0;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #1 RSTa = 1'b0;
    #1;
    checks++; if (Prod !== 64'd0) begin failures++; $display("FAIL abort_prod got=%h exp=0", Prod); end
    checks++; if (Ovf !== 1'b0) begin failures++; $display("FAIL abort_ovf got=%b exp=0", Ovf); end
    checks++; if (Done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", Done); end
    @(posedge CLK); #1 RSTa = 1'b1;
    for (int i = 0; i < 40; i++) begin @(posedge CLK); #1; if (Done) pulses++; end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    run_op(32'd6, 32'd7, 32'd8, p, o, lat);
    checks++; if (lat !== exp_lat(32'd7)) begin failures++; $display("FAIL after_abort_latency got=%0d exp=%0d", lat, exp_lat(32'd7)); end
    checks++; if (p !== 64'd50) begin failures++; $display("FAIL after_abort_prod got=%h exp=%h", p, 64'd50); end
  endtask

  task automatic test_back_to_back;
    int next_acc = 0, exp_done = -1, acc_n = 0, done_n = 0;
    logic [31:0] ac = '0, ad = '0, ar = '0;
    longint e;
    @(posedge CLK); #1;
    for (int c = 0; c < 300; c++) begin
      Coc = 32'(c * 37 - 900); Den = 32'(12345 - c * 1011); Res = 32'(c * 5 - 77);
      Start = acc_n < 3;
      if (c == next_acc && acc_n < 3) begin
        ac = Coc; ad = Den; ar = Res; exp_done = c + exp_lat(Den); acc_n++;
      end
      @(posedge CLK); #1;
      checks++; if (Done !== (c == exp_done)) begin failures++; $display("FAIL b2b_done_c%0d got=%b exp=%b", c, Done, c == exp_done); end
      if (c == exp_done) begin
        e = longint'($signed(ac)) * longint'($signed(ad)) + longint'($signed(ar));
        checks++; if (Prod !== 64'(e)) begin failures++; $display("FAIL b2b_prod%0d got=%h exp=%h", done_n, Prod, 64'(e)); end
        checks++; if (Ovf !== (e > 64'sh7FFFFFFF || e < -64'sh80000000)) begin failures++; $display("FAIL b2b_ovf%0d got=%b", done_n, Ovf); end
        done_n++;
        next_acc = c + 1;
        if (acc_n == 3) break;
      end
    end
    Start = 1'b0;
    checks++; if (done_n !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", done_n); end
    @(posedge CLK); #1;
    checks++; if (Done !== 1'b0) begin failures++; $display("FAIL b2b_done_width got=%b exp=0", Done); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_abort;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
